// File: rtl/crossbar_pkg.sv
// Shared types, constants and width helpers for the N x M round-robin crossbar.
package crossbar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  // Bits needed to index 0..count-1; never below one so degenerate sizes still elaborate.
  function automatic int width_of(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

  // Low bit of lane 'lane' inside a flattened bus of 'width'-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/crossbar_rr_arbiter.sv
// Per-slave round-robin arbiter: IDLE/GRANT/HOLD FSM, rr pointer, grant index
// and the unacked-cycle timer that produces the timeout completion.
module crossbar_rr_arbiter
  import crossbar_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int TIMEOUT   = 16,
  parameter int PTR_W     = width_of(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] cand,
  input  logic                 s_ack,
  output logic                 busy,
  output logic [PTR_W-1:0]     grant,
  output logic                 done_ok,
  output logic                 done_to
);

  localparam int TMR_W = width_of(TIMEOUT + 1);
  localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(N_MASTERS - 1);

  arb_state_t       state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [PTR_W-1:0] grant_reg, grant_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] probe;
  logic             found;
  logic             expired;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign expired = (timer_reg == TMR_W'(TIMEOUT));
    end else begin : g_no_timeout
      assign expired = 1'b0;
    end
  endgenerate

  // Outputs depend only on registered state and s_ack, never on cand,
  // so the master-ack feedback into cand cannot form a combinational loop.
  assign busy    = (state_reg != IDLE);
  assign grant   = grant_reg;
  assign done_ok = busy && s_ack && !reset;
  assign done_to = busy && !s_ack && expired && !reset;

  // Search starts one past the last served master and wraps modulo N_MASTERS.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    probe  = '0;
    for (int off = 1; off <= N_MASTERS; off++) begin
      probe = PTR_W'((int'(ptr_reg) + off) % N_MASTERS);
      if (!found && cand[probe]) begin
        found  = 1'b1;
        winner = probe;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    timer_next = timer_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          grant_next = winner;
          timer_next = '0;
        end
      end
      GRANT, HOLD: begin
        if (s_ack || expired) begin
          state_next = IDLE;
          ptr_next   = grant_reg;
          timer_next = '0;
        end else begin
          state_next = HOLD;
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= PTR_RESET;
      grant_reg <= '0;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      timer_reg <= timer_next;
    end
  end

endmodule

// File: rtl/crossbar_nxm_rr.sv
// N-master x M-slave request/ack crossbar: address decode, per-slave round-robin
// arbiters, routing muxes, ack/rdata merge and the decode-error responder.
module crossbar_nxm_rr
  import crossbar_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int N_SLAVES  = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 2,
  parameter int TIMEOUT   = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEFAULT_ERR_DATA)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS-1:0]          m_cmd,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_err,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
  output logic [N_SLAVES-1:0]           s_req,
  output logic [N_SLAVES*ADDR_W-1:0]    s_addr,
  output logic [N_SLAVES*DATA_W-1:0]    s_wdata,
  output logic [N_SLAVES-1:0]           s_cmd,
  input  logic [N_SLAVES-1:0]           s_ack,
  input  logic [N_SLAVES*DATA_W-1:0]    s_rdata
);

  localparam int PTR_W = width_of(N_MASTERS);
  localparam logic [SEL_W:0] SLAVE_LIMIT = (SEL_W + 1)'(N_SLAVES);

  logic [ADDR_W-1:0]    addr_a  [N_MASTERS];
  logic [DATA_W-1:0]    wdata_a [N_MASTERS];
  logic [SEL_W-1:0]     sel_a   [N_MASTERS];
  logic [DATA_W-1:0]    rdata_v [N_MASTERS];
  logic [N_MASTERS-1:0] bad;
  logic [N_MASTERS-1:0] ack_v;
  logic [N_MASTERS-1:0] err_v;
  logic [N_MASTERS-1:0] err_pend_reg;
  logic [N_MASTERS-1:0] err_ack_reg;
  logic [N_MASTERS-1:0] cand  [N_SLAVES];
  logic [PTR_W-1:0]     grant [N_SLAVES];
  logic [N_SLAVES-1:0]  busy;
  logic [N_SLAVES-1:0]  done_ok;
  logic [N_SLAVES-1:0]  done_to;

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
    assign addr_a[gi]  = m_addr[lane_lo(gi, ADDR_W) +: ADDR_W];
    assign wdata_a[gi] = m_wdata[lane_lo(gi, DATA_W) +: DATA_W];
    assign sel_a[gi]   = addr_a[gi][ADDR_W-1 -: SEL_W];
    assign bad[gi]     = ({1'b0, sel_a[gi]} >= SLAVE_LIMIT);
    // Outputs are forced quiet while reset is high, so an aborted transfer never acks.
    assign m_ack[gi]   = ack_v[gi] & ~reset;
    assign m_err[gi]   = err_v[gi] & ~reset;
    assign m_rdata[lane_lo(gi, DATA_W) +: DATA_W] = reset ? '0 : rdata_v[gi];
  end

  // Two-stage error responder: pend after the first sampling edge, ack one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_pend_reg <= '0;
      err_ack_reg  <= '0;
    end else begin
      err_pend_reg <= m_req & bad & ~err_pend_reg & ~err_ack_reg;
      err_ack_reg  <= err_pend_reg;
    end
  end

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      ack_v[i]   = err_ack_reg[i];
      err_v[i]   = err_ack_reg[i];
      rdata_v[i] = err_ack_reg[i] ? ERR_DATA : '0;
      for (int s = 0; s < N_SLAVES; s++) begin
        if (grant[s] == PTR_W'(i)) begin
          if (done_ok[s]) begin
            ack_v[i]   = 1'b1;
            err_v[i]   = 1'b0;
            rdata_v[i] = s_rdata[s*DATA_W +: DATA_W];
          end else if (done_to[s]) begin
            ack_v[i]   = 1'b1;
            err_v[i]   = 1'b1;
            rdata_v[i] = ERR_DATA;
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slave
    for (genvar gj = 0; gj < N_MASTERS; gj++) begin : g_cand
      assign cand[gi][gj] = m_req[gj] && (sel_a[gj] == SEL_W'(gi)) && !ack_v[gj];
    end

    crossbar_rr_arbiter #(
      .N_MASTERS (N_MASTERS),
      .TIMEOUT   (TIMEOUT),
      .PTR_W     (PTR_W)
    ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .cand    (cand[gi]),
      .s_ack   (s_ack[gi]),
      .busy    (busy[gi]),
      .grant   (grant[gi]),
      .done_ok (done_ok[gi]),
      .done_to (done_to[gi])
    );

    assign s_req[gi] = busy[gi] & ~reset;
    assign s_addr[lane_lo(gi, ADDR_W) +: ADDR_W]  = s_req[gi] ? addr_a[grant[gi]]  : '0;
    assign s_wdata[lane_lo(gi, DATA_W) +: DATA_W] = s_req[gi] ? wdata_a[grant[gi]] : '0;
    assign s_cmd[gi] = s_req[gi] & m_cmd[grant[gi]];
  end

endmodule

// File: tb/tb_crossbar_nxm_rr.sv
// Directed bench for crossbar_nxm_rr: reset, single read, contention, parallel,
// decode error, timeout and reset abort, with hand-computed expectations.
module tb_crossbar_nxm_rr;

  localparam int NM = 4;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NM-1:0]     m_req, m_cmd, m_ack, m_err;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata, m_rdata;
  logic [NS-1:0]     s_req, s_cmd, s_ack;
  logic [NS*AW-1:0]  s_addr;
  logic [NS*DW-1:0]  s_wdata, s_rdata;
  logic [NS-1:0]     auto_ack, manual_ack;
  int checks = 0;
  int fails  = 0;

  // Contention grant per cycle: -1 = IDLE gap, otherwise the acked master.
  int exp_gnt [17] = '{-1, 0, -1, 1, -1, 2, -1, 3, -1, 0, -1, 1, -1, 2, -1, 3, -1};

  always #5 clk = ~clk;

  // Slave model: zero-wait ack where enabled, plus a manually forced ack line.
  assign s_ack = (s_req & auto_ack) | manual_ack;

  crossbar_nxm_rr #(
    .N_MASTERS (NM),
    .N_SLAVES  (NS),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .SEL_W     (2),
    .TIMEOUT   (16),
    .ERR_DATA  (32'hDEAD_BEEF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m_req   (m_req),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_cmd   (m_cmd),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_rdata (m_rdata),
    .s_req   (s_req),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_cmd   (s_cmd),
    .s_ack   (s_ack),
    .s_rdata (s_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
  endtask

  task automatic set_master(input int i, input logic req, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic cmd);
    m_req[i]             = req;
    m_addr[i*AW +: AW]   = addr;
    m_wdata[i*DW +: DW]  = wdata;
    m_cmd[i]             = cmd;
  endtask

  task automatic reset_dut();
    reset      = 1'b1;
    m_req      = '0;
    m_cmd      = '0;
    m_addr     = '0;
    m_wdata    = '0;
    s_rdata    = '0;
    auto_ack   = '0;
    manual_ack = '0;
    repeat (2) next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    auto_ack   = '1;
    manual_ack = '0;
    s_rdata    = '0;
    for (int i = 0; i < NM; i++) set_master(i, 1'b1, 32'h10 * (i + 1), 32'hA0 + i, 1'b0);
    for (int c = 0; c < 5; c++) begin
      mid_cycle();
      checks++; if ({m_ack, m_err, s_req, s_cmd} !== '0) begin fails++; $display("FAIL reset_ctl cycle %0d: got %b expected 0", c, {m_ack, m_err, s_req, s_cmd}); end
      checks++; if (m_rdata !== '0) begin fails++; $display("FAIL reset_rdata cycle %0d: got %h expected 0", c, m_rdata); end
      checks++; if ({s_addr, s_wdata} !== '0) begin fails++; $display("FAIL reset_route cycle %0d: got %h expected 0", c, {s_addr, s_wdata}); end
      next_cycle();
    end
    reset = 1'b0;
    m_req = 4'b0001;
    mid_cycle();
    checks++; if (s_req !== 3'b000) begin fails++; $display("FAIL post_reset_idle: got %b expected 000", s_req); end
    next_cycle();
    mid_cycle();
    checks++; if (s_req !== 3'b001) begin fails++; $display("FAIL post_reset_sreq: got %b expected 001", s_req); end
    checks++; if (s_addr[0 +: AW] !== 32'h0000_0010) begin fails++; $display("FAIL post_reset_addr: got %h expected 00000010", s_addr[0 +: AW]); end
    checks++; if (m_ack !== 4'b0001) begin fails++; $display("FAIL post_reset_ack: got %b expected 0001", m_ack); end
    $display("txn reset_first_grant: m0 -> s0 ack=%b", m_ack);
    next_cycle();
    m_req = '0;
  endtask

  task automatic test_single_read();
    reset_dut();
    s_rdata[DW +: DW] = 32'd1000;
    auto_ack = 3'b010;
    set_master(0, 1'b1, 32'h4000_0004, 32'h55, 1'b0);
    mid_cycle();
    checks++; if ({s_req, m_ack} !== '0) begin fails++; $display("FAIL read_latency: got %b expected 0", {s_req, m_ack}); end
    next_cycle();
    mid_cycle();
    checks++; if (s_req !== 3'b010) begin fails++; $display("FAIL read_sreq: got %b expected 010", s_req); end
    checks++; if (m_ack !== 4'b0001) begin fails++; $display("FAIL read_ack: got %b expected 0001", m_ack); end
    checks++; if (m_err !== 4'b0000) begin fails++; $display("FAIL read_err: got %b expected 0000", m_err); end
    checks++; if (m_rdata[0 +: DW] !== 32'd1000) begin fails++; $display("FAIL read_rdata: got %0d expected 1000", m_rdata[0 +: DW]); end
    checks++; if (s_addr[AW +: AW] !== 32'h4000_0004) begin fails++; $display("FAIL read_addr: got %h expected 40000004", s_addr[AW +: AW]); end
    $display("txn single_read: m0 -> s1 rdata=%0d", m_rdata[0 +: DW]);
    next_cycle();
    m_req = '0;
    mid_cycle();
    checks++; if ({s_req, m_ack} !== '0) begin fails++; $display("FAIL read_done: got %b expected 0", {s_req, m_ack}); end
  endtask

  task automatic test_contention();
    logic [NM-1:0] want_ack;
    reset_dut();
    auto_ack = 3'b001;
    s_rdata[0 +: DW] = 32'd777;
    for (int i = 0; i < NM; i++) set_master(i, 1'b1, 32'h100 + 4 * i, 32'h1000 + i, i[0]);
    for (int c = 0; c < 17; c++) begin
      if (c > 0) next_cycle();
      if (c >= 10 && c % 2 == 0) m_req[(c - 10) / 2] = 1'b0;
      mid_cycle();
      want_ack = (exp_gnt[c] >= 0) ? NM'(1 << exp_gnt[c]) : '0;
      checks++; if (m_ack !== want_ack) begin fails++; $display("FAIL contention_ack cycle %0d: got %b expected %b", c, m_ack, want_ack); end
      checks++; if (s_req[0] !== (exp_gnt[c] >= 0)) begin fails++; $display("FAIL contention_sreq cycle %0d: got %b expected %b", c, s_req[0], exp_gnt[c] >= 0); end
      if (exp_gnt[c] >= 0) begin
        checks++; if (s_addr[0 +: AW] !== 32'h100 + 4 * exp_gnt[c]) begin fails++; $display("FAIL contention_addr cycle %0d: got %h expected %h", c, s_addr[0 +: AW], 32'h100 + 4 * exp_gnt[c]); end
        checks++; if (s_cmd[0] !== exp_gnt[c][0]) begin fails++; $display("FAIL contention_cmd cycle %0d: got %b expected %b", c, s_cmd[0], exp_gnt[c][0]); end
        checks++; if (m_rdata[exp_gnt[c]*DW +: DW] !== 32'd777) begin fails++; $display("FAIL contention_rdata cycle %0d: got %0d expected 777", c, m_rdata[exp_gnt[c]*DW +: DW]); end
        $display("txn contention cycle %0d: m%0d -> s0", c, exp_gnt[c]);
      end
    end
  endtask

  task automatic test_parallel();
    reset_dut();
    auto_ack = 3'b101;
    s_rdata[0 +: DW]    = 32'd111;
    s_rdata[2*DW +: DW] = 32'd222;
    set_master(0, 1'b1, 32'h0000_0020, 32'hAAAA, 1'b0);
    set_master(1, 1'b1, 32'h8000_0000, 32'hBBBB, 1'b1);
    mid_cycle();
    checks++; if (s_req !== 3'b000) begin fails++; $display("FAIL parallel_idle: got %b expected 000", s_req); end
    next_cycle();
    mid_cycle();
    checks++; if (s_req !== 3'b101) begin fails++; $display("FAIL parallel_sreq: got %b expected 101", s_req); end
    checks++; if (m_ack !== 4'b0011) begin fails++; $display("FAIL parallel_ack: got %b expected 0011", m_ack); end
    checks++; if (m_rdata[0 +: DW] !== 32'd111) begin fails++; $display("FAIL parallel_rdata0: got %0d expected 111", m_rdata[0 +: DW]); end
    checks++; if (m_rdata[DW +: DW] !== 32'd222) begin fails++; $display("FAIL parallel_rdata1: got %0d expected 222", m_rdata[DW +: DW]); end
    checks++; if (s_addr[2*AW +: AW] !== 32'h8000_0000) begin fails++; $display("FAIL parallel_addr2: got %h expected 80000000", s_addr[2*AW +: AW]); end
    checks++; if (s_wdata[2*DW +: DW] !== 32'hBBBB) begin fails++; $display("FAIL parallel_wdata2: got %h expected 0000bbbb", s_wdata[2*DW +: DW]); end
    checks++; if (s_cmd !== 3'b100) begin fails++; $display("FAIL parallel_cmd: got %b expected 100", s_cmd); end
    checks++; if (s_addr[AW +: AW] !== '0) begin fails++; $display("FAIL parallel_ungranted: got %h expected 0", s_addr[AW +: AW]); end
    $display("txn parallel: m0 -> s0 rdata=%0d, m1 -> s2 rdata=%0d", m_rdata[0 +: DW], m_rdata[DW +: DW]);
    next_cycle();
    m_req = '0;
    mid_cycle();
    checks++; if (s_req !== 3'b000) begin fails++; $display("FAIL parallel_done: got %b expected 000", s_req); end
  endtask

  task automatic test_decode_error();
    reset_dut();
    auto_ack = '1;
    set_master(2, 1'b1, 32'hC000_0000, 32'h0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      if (c > 0) next_cycle();
      mid_cycle();
      checks++; if ({m_ack, s_req} !== '0) begin fails++; $display("FAIL decerr_wait cycle %0d: got %b expected 0", c, {m_ack, s_req}); end
    end
    next_cycle();
    mid_cycle();
    checks++; if (m_ack !== 4'b0100) begin fails++; $display("FAIL decerr_ack: got %b expected 0100", m_ack); end
    checks++; if (m_err !== 4'b0100) begin fails++; $display("FAIL decerr_err: got %b expected 0100", m_err); end
    checks++; if (m_rdata[2*DW +: DW] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL decerr_rdata: got %h expected deadbeef", m_rdata[2*DW +: DW]); end
    checks++; if (s_req !== 3'b000) begin fails++; $display("FAIL decerr_sreq: got %b expected 000", s_req); end
    $display("txn decode_error: m2 addr c0000000 err=%b", m_err);
    next_cycle();
    m_req = '0;
    mid_cycle();
    checks++; if (m_ack !== 4'b0000) begin fails++; $display("FAIL decerr_done: got %b expected 0000", m_ack); end
  endtask

  task automatic test_timeout_and_abort();
    reset_dut();
    set_master(0, 1'b1, 32'h4000_0000, 32'h0, 1'b0);
    set_master(1, 1'b1, 32'h4000_0008, 32'h0, 1'b0);
    mid_cycle();
    // 16 unacked s_req cycles, then the error ack lands in the 17th.
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      mid_cycle();
      checks++; if (s_req !== 3'b010) begin fails++; $display("FAIL timeout_sreq cycle %0d: got %b expected 010", c, s_req); end
      checks++; if (m_ack !== 4'b0000) begin fails++; $display("FAIL timeout_early_ack cycle %0d: got %b expected 0000", c, m_ack); end
    end
    next_cycle();
    mid_cycle();
    checks++; if (m_ack !== 4'b0001) begin fails++; $display("FAIL timeout_ack: got %b expected 0001", m_ack); end
    checks++; if (m_err !== 4'b0001) begin fails++; $display("FAIL timeout_err: got %b expected 0001", m_err); end
    checks++; if (m_rdata[0 +: DW] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL timeout_rdata: got %h expected deadbeef", m_rdata[0 +: DW]); end
    $display("txn timeout: m0 -> s1 err=%b rdata=%h", m_err[0], m_rdata[0 +: DW]);
    next_cycle();
    m_req[0]   = 1'b0;
    manual_ack = 3'b010;
    mid_cycle();
    checks++; if (s_req !== 3'b000) begin fails++; $display("FAIL timeout_drop: got %b expected 000", s_req); end
    checks++; if (m_ack !== 4'b0000) begin fails++; $display("FAIL late_ack_ignored: got %b expected 0000", m_ack); end
    next_cycle();
    manual_ack = '0;
    mid_cycle();
    checks++; if (s_req !== 3'b010) begin fails++; $display("FAIL timeout_next_sreq: got %b expected 010", s_req); end
    checks++; if (s_addr[AW +: AW] !== 32'h4000_0008) begin fails++; $display("FAIL timeout_next_grant: got %h expected 40000008", s_addr[AW +: AW]); end
    next_cycle();
    reset      = 1'b1;
    manual_ack = 3'b010;
    mid_cycle();
    checks++; if (m_ack !== 4'b0000) begin fails++; $display("FAIL abort_no_ack: got %b expected 0000", m_ack); end
    next_cycle();
    mid_cycle();
    checks++; if (s_req !== 3'b000) begin fails++; $display("FAIL abort_sreq: got %b expected 000", s_req); end
    checks++; if (m_ack !== 4'b0000) begin fails++; $display("FAIL abort_ack_after: got %b expected 0000", m_ack); end
    $display("txn reset_abort: m1 -> s1 dropped");
    next_cycle();
    manual_ack = '0;
    m_req      = '0;
    reset      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_parallel();
    test_decode_error();
    test_timeout_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
